// File: rtl/acq_sequencer.sv
// rtl/acq_sequencer.sv - segmented trigger/delay/capture sequencer for the dual-channel ADC path
module acq_sequencer #(
  parameter logic [31:0] ADDR_BASE = 32'h4000_0000,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned SEG_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [SEG_W-1:0] cfg_segments,
  input  logic             trig,
  input  logic [13:0]      adc_A,
  input  logic [13:0]      adc_B,
  output logic [13:0]      data_out_A,
  output logic [13:0]      data_out_B,
  output logic             write_enable,
  output logic [31:0]      write_address,
  output logic             busy,
  output logic             done,
  output logic [SEG_W-1:0] seg_count,
  output logic [7:0]       trig_missed
);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DELAY, S_CAPTURE, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             trig_q;
  logic [CNT_W-1:0] delay_q, delay_d, len_q, len_d, cnt_q, cnt_d;
  logic [SEG_W-1:0] segs_q, segs_d, seg_count_q, seg_count_d, seg_inc;
  logic [7:0]       missed_q, missed_d;
  logic [31:0]      addr_q, addr_d, next_addr_q, next_addr_d;
  logic [13:0]      a_q, a_d, b_q, b_d;
  logic             we_q, we_d, done_q, done_d;
  logic             trig_edge;

  assign trig_edge = trig & ~trig_q;
  assign seg_inc   = seg_count_q + SEG_W'(1);

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    len_d       = len_q;
    segs_d      = segs_q;
    cnt_d       = cnt_q;
    seg_count_d = seg_count_q;
    missed_d    = missed_q;
    addr_d      = addr_q;
    next_addr_d = next_addr_q;
    a_d         = a_q;
    b_d         = b_q;
    we_d        = 1'b0;
    done_d      = 1'b0;

    if (trig_edge && (state_q == S_DELAY || state_q == S_CAPTURE) && missed_q != 8'hFF)
      missed_d = missed_q + 8'd1;

    // abort freezes the status counters, so the missed-edge increment is undone here
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      missed_d = missed_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            delay_d     = cfg_delay;
            len_d       = cfg_len;
            segs_d      = cfg_segments;
            seg_count_d = '0;
            missed_d    = 8'd0;
            addr_d      = ADDR_BASE;
            next_addr_d = ADDR_BASE;
            cnt_d       = '0;
            state_d     = (cfg_len == '0 || cfg_segments == '0) ? S_DONE : S_ARMED;
          end
        end
        S_ARMED: begin
          if (trig_edge) begin
            if (delay_q == '0) begin
              cnt_d   = '0;
              state_d = S_CAPTURE;
            end else begin
              cnt_d   = delay_q - CNT_W'(1);
              state_d = S_DELAY;
            end
          end
        end
        S_DELAY: begin
          if (cnt_q == '0) state_d = S_CAPTURE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        S_CAPTURE: begin
          we_d        = 1'b1;
          a_d         = adc_A;
          b_d         = adc_B;
          addr_d      = next_addr_q;
          next_addr_d = next_addr_q + 32'd1;
          // cnt counts writes within the segment; the delay countdown left it at zero
          if (cnt_q == len_q - CNT_W'(1)) begin
            cnt_d       = '0;
            seg_count_d = seg_inc;
            state_d     = (seg_inc == segs_q) ? S_DONE : S_ARMED;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      trig_q      <= 1'b0;
      delay_q     <= '0;
      len_q       <= '0;
      segs_q      <= '0;
      cnt_q       <= '0;
      seg_count_q <= '0;
      missed_q    <= 8'd0;
      addr_q      <= ADDR_BASE;
      next_addr_q <= ADDR_BASE;
      a_q         <= 14'd0;
      b_q         <= 14'd0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_q      <= trig;
      delay_q     <= delay_d;
      len_q       <= len_d;
      segs_q      <= segs_d;
      cnt_q       <= cnt_d;
      seg_count_q <= seg_count_d;
      missed_q    <= missed_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      we_q        <= we_d;
      done_q      <= done_d;
    end
  end

  assign data_out_A    = a_q;
  assign data_out_B    = b_q;
  assign write_enable  = we_q;
  assign write_address = addr_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign seg_count     = seg_count_q;
  assign trig_missed   = missed_q;

endmodule
